// File: rtl/mod_check_serial.sv
// mod_check_serial: streaming word-mod-DIVISOR reducer, MSB-first, BPC bits per cycle over valid/ready
module mod_check_serial #(
  parameter int DATA_W = 32,
  parameter int DIVISOR = 3,
  parameter int BPC = 1,
  localparam int RW = $clog2(DIVISOR),
  localparam int N = DATA_W / BPC,
  localparam int CW = $clog2(N + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RW-1:0]     remainder,
  output logic              divisible,
  output logic              busy
);
  if (BPC < 1 || DIVISOR < 2 || DATA_W % BPC != 0) begin : g_bad_params
    $error("mod_check_serial: illegal DATA_W/DIVISOR/BPC combination");
  end
  localparam logic [RW:0] D = (RW + 1)'(DIVISOR);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t            st_q, st_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [RW-1:0]     res_q, res_d, r_nx;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              div_q, div_d;
  logic [RW:0]       t;
  // {r, b} is 2r+b; one conditional subtract keeps r below DIVISOR
  always_comb begin
    r_nx = res_q;
    t = '0;
    for (int i = 0; i < BPC; i++) begin
      t = {r_nx, sh_q[DATA_W-1-i]};
      r_nx = RW'(t >= D ? t - D : t);
    end
  end
  always_comb begin
    st_d = st_q;
    sh_d = sh_q;
    res_d = res_q;
    cnt_d = cnt_q;
    div_d = div_q;
    case (st_q)
      IDLE: if (in_valid) begin
        st_d = RUN;
        sh_d = in_data;
        res_d = '0;
        cnt_d = CW'(N);
        div_d = 1'b0;
      end
      RUN: begin
        sh_d = sh_q << BPC;
        res_d = r_nx;
        cnt_d = cnt_q - CW'(1);
        st_d = cnt_q == CW'(1) ? DONE : RUN;
        div_d = r_nx == '0;
      end
      DONE: st_d = out_ready ? IDLE : DONE;
      default: st_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q <= IDLE;
      sh_q <= '0;
      res_q <= '0;
      cnt_q <= '0;
      div_q <= 1'b0;
    end else begin
      st_q <= st_d;
      sh_q <= sh_d;
      res_q <= res_d;
      cnt_q <= cnt_d;
      div_q <= div_d;
    end
  end
  assign in_ready = st_q == IDLE;
  assign out_valid = st_q == DONE;
  assign busy = st_q != IDLE;
  assign remainder = res_q;
  assign divisible = div_q;
endmodule

// File: tb/tb_mod_check_serial.sv
// tb_mod_check_serial: three configs in parallel, queue scoreboard against plain % arithmetic
module tb_mod_check_serial;
  localparam int NC = 3;
  localparam int NW = 2500;
  localparam int DW[NC] = '{8, 32, 16};
  localparam int DV[NC] = '{3, 7, 10};
  localparam int BP[NC] = '{1, 4, 2};
  logic [31:0] dirs[NC][3] = '{'{32'hFF, 32'hFE, 32'h0}, '{32'hFFFFFFFF, 32'h7, 32'h0}, '{32'd1234, 32'd65535, 32'h0}};
  logic clk = 1'b0;
  logic rst_n;
  logic vin[NC], rin[NC], vout[NC], rout[NC], dvs[NC], bsy[NC];
  logic [31:0] din[NC], rem[NC];
  logic [31:0] qd[NC][$];
  int qc[NC][$];
  int ncmp = 0, nfail = 0, cyc = 0, phase = 0;
  int nacc[NC], nres[NC];
  bit done[NC];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [31:0] msk(input int k);
    return DW[k] == 32 ? 32'hFFFFFFFF : (32'd1 << DW[k]) - 32'd1;
  endfunction
  task automatic chk(input string nm, input int k, input longint act, input longint exp);
    ncmp++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s[%0d] @cyc %0d: got %0d, expected %0d", nm, k, cyc, act, exp);
    end
  endtask
  task automatic flag(input string nm, input int k);
    ncmp++;
    nfail++;
    $display("FAIL %s[%0d] @cyc %0d: expected event did not happen as required", nm, k, cyc);
  endtask
  task automatic send(input int k, input logic [31:0] d, input bit keep);
    int n;
    bit r;
    n = 0;
    r = 1'b0;
    vin[k] = 1'b1;
    din[k] = d & msk(k);
    while (!r && n < 500) begin
      @(negedge clk);
      r = rin[k];
      @(posedge clk);
      #1;
      n++;
    end
    vin[k] = 1'b0;
    din[k] = $urandom;
    if (!r) flag("accept_timeout", k);
    else if (keep) begin
      qd[k].push_back(d & msk(k));
      qc[k].push_back(cyc);
      nacc[k]++;
    end
  endtask
  for (genvar g = 0; g < NC; g++) begin : gi
    localparam int RW = $clog2(DV[g]);
    localparam int N = DW[g] / BP[g];
    logic [RW-1:0] r_w;
    assign rem[g] = 32'(r_w);
    mod_check_serial #(.DATA_W(DW[g]), .DIVISOR(DV[g]), .BPC(BP[g])) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(vin[g]), .in_ready(rin[g]), .in_data(din[g][DW[g]-1:0]),
      .out_valid(vout[g]), .out_ready(rout[g]), .remainder(r_w), .divisible(dvs[g]), .busy(bsy[g]));
    bit pend = 1'b0;
    logic [31:0] prem, md;
    logic pdiv;
    int mc;
    initial forever begin
      @(negedge clk);
      if (!rst_n) pend = 1'b0;
      else if (vout[g]) begin
        if (!pend) begin
          if (qd[g].size() == 0) flag("unexpected_result", g);
          else begin
            md = qd[g].pop_front();
            mc = qc[g].pop_front();
            chk("remainder", g, rem[g], md % DV[g]);
            chk("divisible", g, dvs[g], (md % DV[g]) == 0);
            chk("latency", g, cyc, mc + N);
            nres[g]++;
          end
          pend = 1'b1;
          prem = rem[g];
          pdiv = dvs[g];
        end else begin
          chk("hold_remainder", g, rem[g], prem);
          chk("hold_divisible", g, dvs[g], pdiv);
        end
        chk("in_ready_in_done", g, rin[g], 0);
        if (rout[g]) pend = 1'b0;
      end
    end
    initial begin
      wait (phase == 2);
      forever begin
        @(posedge clk);
        #1;
        rout[g] = $urandom_range(0, 3) != 0;
      end
    end
    initial begin
      int n, sel;
      logic [31:0] d;
      wait (phase == 2);
      for (int i = 0; i < 3; i++) send(g, dirs[g][i], 1'b1);
      for (int i = 0; i < NW; i++) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
        sel = $urandom_range(0, 7);
        d = sel == 0 ? 32'h0 : sel == 1 ? 32'hFFFFFFFF : $urandom;
        send(g, d, 1'b1);
      end
      n = 0;
      while (qd[g].size() != 0 && n < 1000) begin
        @(posedge clk);
        n++;
      end
      chk("queue_drained", g, qd[g].size(), 0);
      chk("one_result_per_word", g, nres[g], nacc[g]);
      done[g] = 1'b1;
    end
  end
  initial begin
    int n;
    rst_n = 1'b0;
    for (int k = 0; k < NC; k++) begin
      vin[k] = 1'b0;
      rout[k] = 1'b1;
      din[k] = '0;
      nacc[k] = 0;
      nres[k] = 0;
      done[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    phase = 1;
    for (int k = 0; k < NC; k++) begin
      chk("rst_in_ready", k, rin[k], 1);
      chk("rst_out_valid", k, vout[k], 0);
      chk("rst_remainder", k, rem[k], 0);
      chk("rst_divisible", k, dvs[k], 0);
      chk("rst_busy", k, bsy[k], 0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rout[0] = 1'b0;
    send(0, 32'hFF, 1'b1);
    n = 0;
    while (!vout[0] && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!vout[0]) flag("bp_result_timeout", 0);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    chk("bp_valid_held", 0, vout[0], 1);
    rout[0] = 1'b1;
    @(posedge clk);
    #1;
    rout[0] = 1'b0;
    chk("bp_release_in_ready", 0, rin[0], 1);
    chk("bp_release_out_valid", 0, vout[0], 0);
    rout[0] = 1'b1;
    send(0, 32'h5A, 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("run_busy", 0, bsy[0], 1);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 0, vout[0], 0);
    chk("abort_busy", 0, bsy[0], 0);
    chk("abort_in_ready", 0, rin[0], 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(0, 32'd9, 1'b1);
    n = 0;
    while (qd[0].size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    chk("post_abort_drained", 0, qd[0].size(), 0);
    @(posedge clk);
    #1;
    phase = 2;
    n = 0;
    while (!(done[0] && done[1] && done[2]) && n < 90000) begin
      @(posedge clk);
      n++;
    end
    for (int k = 0; k < NC; k++) if (!done[k]) flag("regression_timeout", k);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
